trap_unit: RTL and testbench

Machine-mode trap controller and minimal CSR file for the single-cycle NPC core. It produces the exception redirect consumed by the fetch stage: `ex`/`ex_entry` on trap entry and `ex_ret`/`epc` on `mret`. It also holds the M-mode CSRs those redirects depend on. Trap decisions are combinational in the commit cycle, so the fetch stage's combinational next-PC select redirects on the following edge. All CSR state updates on that same edge.

---
 rtl/trap_pkg.sv | 36 +++
 rtl/trap_csr_wval.sv | 25 ++
 rtl/trap_unit.sv | 139 +++++++++++++
 tb/tb_trap_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared constants for the M-mode trap controller: CSR addresses, cause codes,
// csr_op encoding and mstatus/mie/mip bit positions.
// Pure declarations, no logic; no flow control.
package trap_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

  // Cause codes; the interrupt cause additionally sets the top bit of mcause.
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  // Bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;  // two bits, 12:11, hard-wired to M-mode
  localparam int MIE_MTIE     = 7;
  localparam int MIP_MTIP     = 7;

endpackage

// File: rtl/trap_csr_wval.sv
// New CSR value for CSRRW/CSRRS/CSRRC from the old value and the operand.
// Latency: combinational. Backpressure: none.
// Ports: old (current CSR value), wdata (rs1/zimm), op (csr_op_e), wval (value to write).
module trap_csr_wval
  import trap_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] old,
  input  logic [WIDTH-1:0] wdata,
  input  csr_op_e          op,
  output logic [WIDTH-1:0] wval
);

  always_comb begin
    wval = old;
    case (op)
      CSR_RW:  wval = wdata;
      CSR_RS:  wval = old | wdata;
      CSR_RC:  wval = old & ~wdata;
      default: wval = old;
    endcase
  end

endmodule

// File: rtl/trap_unit.sv
// M-mode trap controller and minimal CSR file; drives the fetch redirect.
// Latency: ex/ex_ret/ex_entry/csr_rdata combinational in the commit cycle; CSR state at next posedge.
// Backpressure: none; one commit per cycle, the core never stalls this block.
// Ports: clk/rst (sync, active-high); inst_valid/inst_pc/is_* decode flags; csr_op/csr_addr/
//        csr_wdata in, csr_rdata out (pre-write value); irq_timer level; ex/ex_entry, ex_ret/epc out.
module trap_unit
  import trap_pkg::*;
#(
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] TVEC_RESET = 64'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic [WIDTH-1:0] inst_pc,
  input  logic             is_ecall,
  input  logic             is_ebreak,
  input  logic             is_mret,
  input  logic             is_illegal,
  input  logic [1:0]       csr_op,
  input  logic [11:0]      csr_addr,
  input  logic [WIDTH-1:0] csr_wdata,
  output logic [WIDTH-1:0] csr_rdata,
  input  logic             irq_timer,
  output logic             ex,
  output logic [WIDTH-1:0] ex_entry,
  output logic             ex_ret,
  output logic [WIDTH-1:0] epc
);

  logic             mst_mie, mst_mpie, mie_mtie;
  logic [WIDTH-1:0] mtvec, mscratch, mepc, mcause, mcycle;

  logic [WIDTH-1:0] csr_old, csr_new, trap_cause, tvec_base;
  logic             csr_writable, csr_we, irq_take, exc_take;

  // Read mux; csr_writable excludes read-only mip and unknown addresses.
  always_comb begin
    csr_old      = '0;
    csr_writable = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_old[MSTATUS_MIE]                 = mst_mie;
        csr_old[MSTATUS_MPIE]                = mst_mpie;
        csr_old[MSTATUS_MPP+1:MSTATUS_MPP]   = 2'b11;
      end
      CSR_MIE:      csr_old[MIE_MTIE] = mie_mtie;
      CSR_MTVEC:    csr_old = mtvec;
      CSR_MSCRATCH: csr_old = mscratch;
      CSR_MEPC:     csr_old = mepc;
      CSR_MCAUSE:   csr_old = mcause;
      CSR_MCYCLE:   csr_old = mcycle;
      CSR_MIP: begin
        csr_old[MIP_MTIP] = irq_timer;
        csr_writable      = 1'b0;
      end
      default:      csr_writable = 1'b0;
    endcase
  end

  trap_csr_wval #(.WIDTH(WIDTH)) u_wval (
    .old   (csr_old),
    .wdata (csr_wdata),
    .op    (csr_op_e'(csr_op)),
    .wval  (csr_new)
  );

  // MIE is sampled from the register, so a CSR write setting it only
  // affects later instructions.
  assign irq_take = inst_valid & mst_mie & mie_mtie & irq_timer;
  assign exc_take = inst_valid & (is_illegal | is_ebreak | is_ecall);

  assign ex     = ~rst & (irq_take | exc_take);
  assign ex_ret = ~rst & inst_valid & is_mret & ~ex;
  assign csr_we = ~rst & inst_valid & (csr_op != CSR_NONE) & csr_writable & ~ex & ~ex_ret;

  always_comb begin
    trap_cause = '0;
    if (irq_take) begin
      trap_cause[WIDTH-1] = 1'b1;
      trap_cause[3:0]     = CAUSE_MTI;
    end else if (is_illegal) begin
      trap_cause[3:0] = CAUSE_ILLEGAL;
    end else if (is_ebreak) begin
      trap_cause[3:0] = CAUSE_EBREAK;
    end else begin
      trap_cause[3:0] = CAUSE_ECALL;
    end
  end

  // Vectored mode offsets interrupts by 4*cause; exceptions always go to base.
  assign tvec_base = {mtvec[WIDTH-1:2], 2'b00};
  assign ex_entry  = (mtvec[1:0] == 2'b01 && irq_take)
                   ? tvec_base + (WIDTH'(CAUSE_MTI) << 2) : tvec_base;

  assign csr_rdata = rst ? '0 : csr_old;
  assign epc       = mepc;

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
      mie_mtie <= 1'b0;
      mtvec    <= TVEC_RESET;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
    end else begin
      // Write to mcycle overrides this cycle's increment.
      if (csr_we && csr_addr == CSR_MCYCLE) mcycle <= csr_new;
      else                                  mcycle <= mcycle + 1'b1;

      if (ex) begin
        mepc     <= inst_pc;
        mcause   <= trap_cause;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (ex_ret) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mst_mie  <= csr_new[MSTATUS_MIE];
            mst_mpie <= csr_new[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_mtie <= csr_new[MIE_MTIE];
          CSR_MTVEC:    mtvec    <= csr_new;
          CSR_MSCRATCH: mscratch <= csr_new;
          CSR_MEPC:     mepc     <= {csr_new[WIDTH-1:2], 2'b00};
          CSR_MCAUSE:   mcause   <= csr_new;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: each driven cycle pushes its expected outputs,
// a negedge monitor pops and compares against the combinational outputs.
module tb_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [63:0] inst_pc;
  logic        is_ecall, is_ebreak, is_mret, is_illegal;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        irq_timer;
  logic        ex, ex_ret;
  logic [63:0] ex_entry, epc;

  always #5 clk = ~clk;

  trap_unit dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret), .is_illegal(is_illegal),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .irq_timer(irq_timer), .ex(ex), .ex_entry(ex_entry), .ex_ret(ex_ret), .epc(epc)
  );

  // Check mask: E = ex/ex_ret, N = ex_entry, R = csr_rdata, P = epc
  localparam logic [3:0] E = 4'b0001, N = 4'b0010, R = 4'b0100, P = 4'b1000;

  typedef struct packed {
    logic [3:0]  m;
    logic        ex;
    logic        ret;
    logic [63:0] ent;
    logic [63:0] rd;
    logic [63:0] ep;
    logic [7:0]  id;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  function automatic exp_t ck(input logic [3:0] m, input logic x, input logic r,
                              input logic [63:0] ent, input logic [63:0] rd,
                              input logic [63:0] ep, input logic [7:0] id);
    exp_t e;
    e.m = m; e.ex = x; e.ret = r; e.ent = ent; e.rd = rd; e.ep = ep; e.id = id;
    return e;
  endfunction

  // Monitor: outputs are combinational, so they are stable at the negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) begin
        total++;
        if (ex !== e.ex || ex_ret !== e.ret) begin
          bad++;
          $display("FAIL step%0d ex/ex_ret got=%b%b want=%b%b", e.id, ex, ex_ret, e.ex, e.ret);
        end
      end
      if (e.m[1]) begin
        total++;
        if (ex_entry !== e.ent) begin
          bad++;
          $display("FAIL step%0d ex_entry got=%h want=%h", e.id, ex_entry, e.ent);
        end
      end
      if (e.m[2]) begin
        total++;
        if (csr_rdata !== e.rd) begin
          bad++;
          $display("FAIL step%0d csr_rdata got=%h want=%h", e.id, csr_rdata, e.rd);
        end
      end
      if (e.m[3]) begin
        total++;
        if (epc !== e.ep) begin
          bad++;
          $display("FAIL step%0d epc got=%h want=%h", e.id, epc, e.ep);
        end
      end
    end
  end

  task automatic drv(input logic v, input logic [1:0] o, input logic [11:0] a,
                     input logic [63:0] d, input logic [63:0] pc);
    inst_valid = v; csr_op = o; csr_addr = a; csr_wdata = d; inst_pc = pc;
    is_ecall = 1'b0; is_ebreak = 1'b0; is_mret = 1'b0; is_illegal = 1'b0;
  endtask

  task automatic go(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] NO = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;

  initial begin
    rst = 1'b1; irq_timer = 1'b0;
    drv(1, NO, 12'h300, 0, 64'h100);
    is_ecall = 1'b1;
    @(posedge clk); #1;
    // Reset held with a trap request: no trap, rdata forced to 0
    go(ck(E|R, 0, 0, 0, 0, 0, 1));
    rst = 1'b0;

    drv(0, NO, 12'h305, 0, 0);                go(ck(E|R|P, 0, 0, 0, 64'h8000_0000, 0, 2));
    drv(0, NO, 12'h300, 0, 0);                go(ck(E|R, 0, 0, 0, 64'h1800, 0, 3));
    drv(1, RW, 12'h305, 64'h8000_1000, 0);    go(ck(E|R, 0, 0, 0, 64'h8000_0000, 0, 4));
    drv(1, RS, 12'h300, 64'h8, 0);            go(ck(E|R, 0, 0, 0, 64'h1800, 0, 5));
    // ecall with MIE=1
    drv(1, NO, 12'h300, 0, 64'h8000_0040); is_ecall = 1'b1;
    go(ck(E|N|R|P, 1, 0, 64'h8000_1000, 64'h1808, 0, 6));
    drv(0, NO, 12'h342, 0, 0);                go(ck(E|R|P, 0, 0, 0, 64'd11, 64'h8000_0040, 7));
    drv(0, NO, 12'h300, 0, 0);                go(ck(R, 0, 0, 0, 64'h1880, 0, 8));
    // mret
    drv(1, NO, 12'h300, 0, 64'h8000_1010); is_mret = 1'b1;
    go(ck(E|R|P, 0, 1, 0, 64'h1880, 64'h8000_0040, 9));
    drv(0, NO, 12'h300, 0, 0);                go(ck(E|R, 0, 0, 0, 64'h1888, 0, 10));

    // Vectored timer interrupt with concurrent mscratch write
    drv(1, RW, 12'h305, 64'h8000_1001, 0);    go(ck(R, 0, 0, 0, 64'h8000_1000, 0, 11));
    drv(1, RS, 12'h304, 64'h80, 0);           go(ck(E|R, 0, 0, 0, 64'h0, 0, 12));
    drv(1, RW, 12'h340, 64'h55, 0);           go(ck(R, 0, 0, 0, 64'h0, 0, 13));
    irq_timer = 1'b1;
    drv(1, RW, 12'h340, 64'hAA, 64'h8000_0100);
    go(ck(E|N|R, 1, 0, 64'h8000_101C, 64'h55, 0, 14));
    drv(0, NO, 12'h342, 0, 0);
    go(ck(E|R|P, 0, 0, 0, 64'h8000_0000_0000_0007, 64'h8000_0100, 15));
    // Interrupt still pending but MIE=0: held
    drv(1, NO, 12'h340, 0, 64'h8000_0104);    go(ck(E|R, 0, 0, 0, 64'h55, 0, 16));

    // Priority: illegal beats ecall, interrupt masked; not vectored for exceptions
    drv(1, NO, 12'h342, 0, 64'h8000_0200); is_illegal = 1'b1; is_ecall = 1'b1;
    go(ck(E|N|R, 1, 0, 64'h8000_1000, 64'h8000_0000_0000_0007, 0, 17));
    drv(0, NO, 12'h342, 0, 0);                go(ck(R|P, 0, 0, 0, 64'd2, 64'h8000_0200, 18));
    // Setting MIE does not apply to the writing instruction
    drv(1, RS, 12'h300, 64'h8, 64'h8000_0300); go(ck(E|R, 0, 0, 0, 64'h1800, 0, 19));
    drv(1, NO, 12'h300, 0, 64'h8000_0304);
    go(ck(E|N|R, 1, 0, 64'h8000_101C, 64'h1808, 0, 20));
    irq_timer = 1'b0;
    drv(1, RC, 12'h304, 64'h80, 0);           go(ck(E|R, 0, 0, 0, 64'h80, 0, 21));
    drv(0, NO, 12'h304, 0, 0);                go(ck(R, 0, 0, 0, 64'h0, 0, 22));

    // mcycle write beats increment
    drv(1, RW, 12'hB00, 64'd100, 0);          go(ck(E, 0, 0, 0, 0, 0, 23));
    drv(0, NO, 12'hB00, 0, 0);                go(ck(R, 0, 0, 0, 64'd100, 0, 24));
    drv(0, NO, 12'hB00, 0, 0);                go(ck(R, 0, 0, 0, 64'd101, 0, 25));

    // Unknown address, mepc alignment, read-only mip
    drv(1, RW, 12'h7C0, 64'h1234, 0);         go(ck(R, 0, 0, 0, 64'h0, 0, 26));
    drv(0, NO, 12'h7C0, 0, 0);                go(ck(R, 0, 0, 0, 64'h0, 0, 27));
    drv(1, RW, 12'h341, 64'h8000_0403, 0);    go(ck(R|P, 0, 0, 0, 64'h8000_0304, 64'h8000_0304, 28));
    drv(0, NO, 12'h341, 0, 0);                go(ck(R|P, 0, 0, 0, 64'h8000_0400, 64'h8000_0400, 29));
    irq_timer = 1'b1;
    drv(1, RW, 12'h344, 64'h0, 0);            go(ck(R, 0, 0, 0, 64'h80, 0, 30));
    drv(0, NO, 12'h344, 0, 0);                go(ck(R, 0, 0, 0, 64'h80, 0, 31));
    irq_timer = 1'b0;

    // mret and ecall together: trap wins, never both outputs
    drv(1, NO, 12'h340, 0, 64'h8000_0500); is_mret = 1'b1; is_ecall = 1'b1;
    go(ck(E|N, 1, 0, 64'h8000_1000, 0, 0, 32));

    // Reset during a trap: no trap state recorded
    rst = 1'b1;
    drv(1, NO, 12'h341, 0, 64'h8000_0600); is_ecall = 1'b1;
    go(ck(E|R, 0, 0, 0, 64'h0, 0, 33));
    rst = 1'b0;
    drv(0, NO, 12'h341, 0, 0);                go(ck(E|R|P, 0, 0, 0, 64'h0, 64'h0, 34));
    drv(0, NO, 12'h305, 0, 0);                go(ck(R, 0, 0, 0, 64'h8000_0000, 0, 35));

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
